// File: rtl/bp_cfg_stream_loader.sv
// bp_cfg_stream_loader
// Post-reset configuration sequencer for a BlackParrot processor instance.
// For every core it issues freeze, core id, (microcode), coherence mode and
// unfreeze writes as a valid/ready stream, tracking acknowledge credits.
// Optional feature macro: BP_CFG_LOADER_UCODE_EN (microcode load phase).
module bp_cfg_stream_loader #(
    parameter int num_core_p        = 1,
    parameter int cce_pc_width_p    = 8,
    parameter int cce_instr_width_p = 48,
    parameter int cfg_data_width_p  = 64,
    parameter int max_credits_p     = 16,
    parameter int coh_mode_p        = 1,
    localparam int core_width_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int credit_width_lp  = $clog2(max_credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    output logic [cce_pc_width_p-1:0]    ucode_addr_o,
    input  logic [cce_instr_width_p-1:0] ucode_data_i,
    output logic                         cmd_v_o,
    input  logic                         cmd_ready_i,
    output logic [core_width_lp-1:0]     cmd_core_o,
    output logic [15:0]                  cmd_reg_o,
    output logic [cfg_data_width_p-1:0]  cmd_data_o,
    input  logic                         resp_v_i,
    output logic                         resp_yumi_o,
    output logic                         done_o,
    output logic                         error_o
);

    localparam logic [core_width_lp-1:0]   last_core   = core_width_lp'(num_core_p - 1);
    localparam logic [credit_width_lp-1:0] credit_max  = credit_width_lp'(max_credits_p);
    localparam logic [credit_width_lp-1:0] credit_one  = credit_width_lp'(1);
    localparam logic [15:0] reg_freeze     = 16'h0001;
    localparam logic [15:0] reg_core_id    = 16'h0002;
    localparam logic [15:0] reg_coh_mode   = 16'h0003;
    localparam logic [15:0] reg_ucode_base = 16'h8000;

`ifdef BP_CFG_LOADER_UCODE_EN
    localparam logic [cfg_data_width_p-1:0] mode_data = cfg_data_width_p'(coh_mode_p);
    localparam logic [cce_pc_width_p-1:0]   pc_last   = '1;
`else
    // Without microcode the CCEs cannot run coherent, so mode is uncached.
    localparam logic [cfg_data_width_p-1:0] mode_data = '0;
    localparam int unused_coh_mode = coh_mode_p;
`endif

    typedef enum logic [3:0] {
        S_RESET,
        S_FREEZE,
        S_CORE_ID,
`ifdef BP_CFG_LOADER_UCODE_EN
        S_UCODE_FETCH,
        S_UCODE_SEND,
`endif
        S_MODE,
        S_DRAIN,
        S_UNFREEZE,
        S_FINAL_DRAIN,
        S_DONE
    } state_e;

    state_e                       state;
    logic [core_width_lp-1:0]     core;
    logic [core_width_lp-1:0]     core_inc;
    logic                         cmd_pend;
    logic [cfg_data_width_p-1:0]  data_q;
    logic [credit_width_lp-1:0]   credits;
    logic [credit_width_lp-1:0]   credits_next;
    logic                         accept;
    logic                         spurious;

`ifdef BP_CFG_LOADER_UCODE_EN
    logic [cce_pc_width_p-1:0]    pc;
    logic [cce_pc_width_p-1:0]    pc_inc;
    logic                         send_first;
`endif

    // Valid is held back whenever every credit is in use; ready never feeds it.
    assign cmd_v_o     = cmd_pend & (credits != credit_max);
    assign resp_yumi_o = resp_v_i;

`ifdef BP_CFG_LOADER_UCODE_EN
    // First SEND cycle forwards the ROM word directly so a microcode write
    // costs only fetch + send; later stall cycles use the captured copy.
    assign cmd_data_o = send_first ? cfg_data_width_p'(ucode_data_i) : data_q;
`else
    assign cmd_data_o   = data_q;
    assign ucode_addr_o = '0;
    logic unused_ucode_data;
    assign unused_ucode_data = ^ucode_data_i;
`endif

    // Handshake decode, index increments and next credit count.
    always_comb begin
        accept       = cmd_v_o & cmd_ready_i;
        spurious     = resp_v_i & (credits == '0);
        core_inc     = core + core_width_lp'(1);
`ifdef BP_CFG_LOADER_UCODE_EN
        pc_inc       = pc + cce_pc_width_p'(1);
`endif
        credits_next = credits;
        if (spurious) begin
            // An ack with nothing outstanding is dropped; a same-cycle accept still counts.
            credits_next = accept ? credit_one : '0;
        end else if (accept && !resp_v_i) begin
            credits_next = credits + credit_one;
        end else if (!accept && resp_v_i) begin
            credits_next = credits - credit_one;
        end
    end

    // Outstanding-write credit counter and sticky protocol error flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits <= '0;
            error_o <= 1'b0;
        end else begin
            credits <= credits_next;
            if (spurious) begin
                error_o <= 1'b1;
            end
        end
    end

    // Sequencer: walks cores per phase and holds the pending write payload.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= S_RESET;
            core       <= '0;
            cmd_pend   <= 1'b0;
            cmd_core_o <= '0;
            cmd_reg_o  <= '0;
            data_q     <= '0;
            done_o     <= 1'b0;
`ifdef BP_CFG_LOADER_UCODE_EN
            pc           <= '0;
            ucode_addr_o <= '0;
            send_first   <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    state      <= S_FREEZE;
                    core       <= '0;
                    cmd_pend   <= 1'b1;
                    cmd_core_o <= '0;
                    cmd_reg_o  <= reg_freeze;
                    data_q     <= cfg_data_width_p'(1);
                end
                S_FREEZE: begin
                    if (accept) begin
                        if (core == last_core) begin
                            state      <= S_CORE_ID;
                            core       <= '0;
                            cmd_core_o <= '0;
                            cmd_reg_o  <= reg_core_id;
                            data_q     <= '0;
                        end else begin
                            core       <= core_inc;
                            cmd_core_o <= core_inc;
                        end
                    end
                end
                S_CORE_ID: begin
                    if (accept) begin
                        if (core == last_core) begin
                            core <= '0;
`ifdef BP_CFG_LOADER_UCODE_EN
                            state        <= S_UCODE_FETCH;
                            cmd_pend     <= 1'b0;
                            pc           <= '0;
                            ucode_addr_o <= '0;
`else
                            state      <= S_MODE;
                            cmd_core_o <= '0;
                            cmd_reg_o  <= reg_coh_mode;
                            data_q     <= mode_data;
`endif
                        end else begin
                            core       <= core_inc;
                            cmd_core_o <= core_inc;
                            data_q     <= cfg_data_width_p'(core_inc);
                        end
                    end
                end
`ifdef BP_CFG_LOADER_UCODE_EN
                S_UCODE_FETCH: begin
                    state      <= S_UCODE_SEND;
                    send_first <= 1'b1;
                    cmd_pend   <= 1'b1;
                    cmd_core_o <= core;
                    cmd_reg_o  <= reg_ucode_base | 16'(pc);
                end
                S_UCODE_SEND: begin
                    send_first <= 1'b0;
                    if (send_first) begin
                        data_q <= cfg_data_width_p'(ucode_data_i);
                    end
                    if (accept) begin
                        cmd_pend <= 1'b0;
                        if (pc == pc_last) begin
                            if (core == last_core) begin
                                state      <= S_MODE;
                                core       <= '0;
                                cmd_pend   <= 1'b1;
                                cmd_core_o <= '0;
                                cmd_reg_o  <= reg_coh_mode;
                                data_q     <= mode_data;
                            end else begin
                                state        <= S_UCODE_FETCH;
                                core         <= core_inc;
                                pc           <= '0;
                                ucode_addr_o <= '0;
                            end
                        end else begin
                            state        <= S_UCODE_FETCH;
                            pc           <= pc_inc;
                            ucode_addr_o <= pc_inc;
                        end
                    end
                end
`endif
                S_MODE: begin
                    if (accept) begin
                        if (core == last_core) begin
                            state    <= S_DRAIN;
                            cmd_pend <= 1'b0;
                        end else begin
                            core       <= core_inc;
                            cmd_core_o <= core_inc;
                        end
                    end
                end
                S_DRAIN: begin
                    // No core is released until every earlier write is acknowledged.
                    if (credits == '0) begin
                        state      <= S_UNFREEZE;
                        core       <= '0;
                        cmd_pend   <= 1'b1;
                        cmd_core_o <= '0;
                        cmd_reg_o  <= reg_freeze;
                        data_q     <= '0;
                    end
                end
                S_UNFREEZE: begin
                    if (accept) begin
                        if (core == last_core) begin
                            state    <= S_FINAL_DRAIN;
                            cmd_pend <= 1'b0;
                        end else begin
                            core       <= core_inc;
                            cmd_core_o <= core_inc;
                        end
                    end
                end
                S_FINAL_DRAIN: begin
                    if (credits == '0) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cfg_stream_loader.sv
// Testbench for bp_cfg_stream_loader: scoreboard of expected config writes,
// table of sequence scenarios, plus credit-stall and mid-sequence reset cases.
module tb_bp_cfg_stream_loader;

    localparam int NC  = 2;
    localparam int PCW = 3;
    localparam int IW  = 48;
    localparam int DW  = 64;
    localparam int MC  = 2;
    localparam int CW  = 1;
`ifdef BP_CFG_LOADER_UCODE_EN
    localparam int NW              = NC * (4 + (1 << PCW));
    localparam logic [63:0] MODE_D = 64'd1;
    localparam int RESET_AT        = 2 * NC + (1 << PCW) + 5;
`else
    localparam int NW              = 4 * NC;
    localparam logic [63:0] MODE_D = 64'd0;
    localparam int RESET_AT        = 3;
`endif

    typedef struct {
        logic [CW-1:0] core;
        logic [15:0]   rg;
        logic [63:0]   data;
    } exp_wr_t;

    typedef struct {
        bit rand_ready;
        bit spur_ack;
        int exp_writes;
        bit exp_error;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [PCW-1:0] ucode_addr;
    logic [IW-1:0]  ucode_data = '0;
    logic           cmd_v;
    logic           cmd_ready = 1'b0;
    logic [CW-1:0]  cmd_core;
    logic [15:0]    cmd_reg;
    logic [DW-1:0]  cmd_data;
    logic           resp_v = 1'b0;
    logic           resp_yumi;
    logic           done;
    logic           error;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  ack_q = 0;
    int  ack_release = 0;
    int  n_writes = 0;
    int  tick_n = 0;
    bit  rand_ready = 1'b0;
    bit  ack_hold = 1'b0;
    bit  stall_prev = 1'b0;
    bit  done_seen = 1'b0;
    bit  addr_nz = 1'b0;
    logic [CW-1:0] hold_core = '0;
    logic [15:0]   hold_reg = '0;
    logic [63:0]   hold_data = '0;
    int      acc_tick[$];
    exp_wr_t exp_q[$];
    vec_t    vecs[3];

    bp_cfg_stream_loader #(
        .num_core_p(NC),
        .cce_pc_width_p(PCW),
        .cce_instr_width_p(IW),
        .cfg_data_width_p(DW),
        .max_credits_p(MC),
        .coh_mode_p(1)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .ucode_addr_o(ucode_addr),
        .ucode_data_i(ucode_data),
        .cmd_v_o(cmd_v),
        .cmd_ready_i(cmd_ready),
        .cmd_core_o(cmd_core),
        .cmd_reg_o(cmd_reg),
        .cmd_data_o(cmd_data),
        .resp_v_i(resp_v),
        .resp_yumi_o(resp_yumi),
        .done_o(done),
        .error_o(error)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_word(input logic [PCW-1:0] a);
        return 48'hC0DE_5A00_0000 + 48'(a) * 48'h0000_0101_0011;
    endfunction

    // Synchronous microcode ROM: word appears the cycle after the address.
    always @(posedge clk) ucode_data <= rom_word(ucode_addr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int c, input logic [15:0] rg, input logic [63:0] d);
        exp_wr_t e;
        e.core = CW'(c);
        e.rg   = rg;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int c = 0; c < NC; c++) push_exp(c, 16'h0001, 64'd1);
        for (int c = 0; c < NC; c++) push_exp(c, 16'h0002, 64'(c));
`ifdef BP_CFG_LOADER_UCODE_EN
        for (int c = 0; c < NC; c++)
            for (int p = 0; p < (1 << PCW); p++)
                push_exp(c, 16'h8000 + 16'(p), 64'(rom_word(PCW'(p))));
`endif
        for (int c = 0; c < NC; c++) push_exp(c, 16'h0003, MODE_D);
        for (int c = 0; c < NC; c++) push_exp(c, 16'h0001, 64'd0);
    endtask

    task automatic clear_tb();
        cmd_ready  = 1'b0;
        resp_v     = 1'b0;
        ack_q      = 0;
        n_writes   = 0;
        tick_n     = 0;
        stall_prev = 1'b0;
        done_seen  = 1'b0;
        addr_nz    = 1'b0;
        acc_tick.delete();
        exp_q.delete();
    endtask

    // One clock: check stall stability, drive ready/ack, score any transfer.
    task automatic tick();
        exp_wr_t e;
        @(negedge clk);
        tick_n++;
        if (ucode_addr != '0) addr_nz = 1'b1;
        if (done && !done_seen) begin
            done_seen = 1'b1;
            check("done_after_acks", 128'(ack_q), 128'(0));
        end
        if (stall_prev)
            check("stall_stable", 128'({cmd_v, cmd_core, cmd_reg, cmd_data}),
                  128'({1'b1, hold_core, hold_reg, hold_data}));
        cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        resp_v = 1'b0;
        if (ack_q > 0 && (!ack_hold || ack_release > 0)) begin
            resp_v = 1'b1;
            ack_q--;
            if (ack_hold) ack_release--;
        end
        if (cmd_v && cmd_ready) begin
            acc_tick.push_back(tick_n);
            if (cmd_reg == 16'h0001 && cmd_data == 64'd0 && cmd_core == '0)
                check("unfreeze_drained", 128'(ack_q + int'(resp_v)), 128'(0));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_write: got core %0d reg %0h data %0h, expected no write",
                         cmd_core, cmd_reg, cmd_data);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("write%0d", n_writes), 128'({cmd_core, cmd_reg, cmd_data}),
                      128'({e.core, e.rg, e.data}));
            end
            n_writes++;
            ack_q++;
        end
        stall_prev = cmd_v && !cmd_ready;
        hold_core  = cmd_core;
        hold_reg   = cmd_reg;
        hold_data  = cmd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_tb();
        @(negedge clk);
        check("reset_outputs",
              128'({cmd_v, resp_yumi, done, error, ucode_addr, cmd_core, cmd_reg, cmd_data}), 128'(0));
    endtask

    task automatic start_seq(input bit spur);
        build_expected();
        rst    = 1'b0;
        resp_v = spur;
        if (spur) begin
            #1;
            check("yumi_comb", 128'(resp_yumi), 128'(1));
        end
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        if (!done_seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: done_o=%0b after %0d cycles, expected 1", done, budget);
        end
    endtask

    task automatic finish_checks(input int exp_w, input bit exp_err);
        repeat (3) tick();
        check("done_sticky", 128'({done, cmd_v}), 128'(2'b10));
        check("write_count", 128'(n_writes), 128'(exp_w));
        check("sb_empty", 128'(exp_q.size()), 128'(0));
        check("error_flag", 128'(error), 128'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{rand_ready: 1'b0, spur_ack: 1'b0, exp_writes: NW, exp_error: 1'b0};
        vecs[1] = '{rand_ready: 1'b1, spur_ack: 1'b0, exp_writes: NW, exp_error: 1'b0};
        vecs[2] = '{rand_ready: 1'b0, spur_ack: 1'b1, exp_writes: NW, exp_error: 1'b1};

        for (int i = 0; i < 3; i++) begin
            rand_ready = vecs[i].rand_ready;
            ack_hold   = 1'b0;
            do_reset();
            start_seq(vecs[i].spur_ack);
            run_to_done(1000);
            finish_checks(vecs[i].exp_writes, vecs[i].exp_error);
            if (i == 0) begin
                check("first_write_latency", 128'(acc_tick[0]), 128'(1));
                check("regwrite_spacing", 128'(acc_tick[1] - acc_tick[0]), 128'(1));
`ifdef BP_CFG_LOADER_UCODE_EN
                check("ucode_spacing", 128'(acc_tick[5] - acc_tick[4]), 128'(2));
`else
                check("ucode_addr_idle", 128'(addr_nz), 128'(0));
`endif
            end
        end

        // Credit limit: acks withheld, then released one at a time.
        rand_ready  = 1'b0;
        ack_hold    = 1'b1;
        ack_release = 0;
        do_reset();
        start_seq(1'b0);
        repeat (6) tick();
        check("credit_stall_count", 128'(n_writes), 128'(MC));
        check("credit_stall_v", 128'(cmd_v), 128'(0));
        ack_release = 1;
        repeat (6) tick();
        check("credit_one_more", 128'(n_writes), 128'(MC + 1));
        check("credit_one_more_v", 128'(cmd_v), 128'(0));
        ack_hold = 1'b0;
        run_to_done(1000);
        finish_checks(NW, 1'b0);

        // Asynchronous reset in the middle of the sequence, then a clean rerun.
        do_reset();
        start_seq(1'b0);
        n = 0;
        while (n_writes < RESET_AT && n < 500) begin
            tick();
            n++;
        end
        check("reached_reset_point", 128'(n_writes), 128'(RESET_AT));
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_tb();
        #1;
        check("async_reset_outputs",
              128'({cmd_v, resp_yumi, done, error, ucode_addr, cmd_core, cmd_reg, cmd_data}), 128'(0));
        @(negedge clk);
        start_seq(1'b0);
        run_to_done(1000);
        finish_checks(NW, 1'b0);
        check("restart_first_latency", 128'(acc_tick[0]), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
